// File: rtl/div_seq_if.sv
// div_seq_if: operand/result bundle for the sequential divider.
// The div_signed wire exists only when SIGNED_DIV_EN is defined.
interface div_seq_if #(
    parameter int WIDTH = 64
);
    logic             op_start;
    logic             op_clear;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             div_signed;
`endif
    logic             busy;
    logic             op_done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

`ifdef SIGNED_DIV_EN
    modport master (
        output op_start, op_clear, dividend, divisor, div_signed,
        input  busy, op_done, div_zero, quotient, remainder
    );
    modport slave (
        input  op_start, op_clear, dividend, divisor, div_signed,
        output busy, op_done, div_zero, quotient, remainder
    );
`else
    modport master (
        output op_start, op_clear, dividend, divisor,
        input  busy, op_done, div_zero, quotient, remainder
    );
    modport slave (
        input  op_start, op_clear, dividend, divisor,
        output busy, op_done, div_zero, quotient, remainder
    );
`endif
endinterface

// File: rtl/div_seq.sv
// div_seq: restoring divider, one quotient bit per clock, IDLE/EXEC/DONE FSM.
// Define SIGNED_DIV_EN to add two's-complement mode via bus.div_signed.
module div_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic      clk,
    input  logic      reset_n,
    div_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             busy_q, done_q, dzo_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SIGNED_DIV_EN
    assign a_neg = bus.div_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.div_signed & bus.divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

    // WIDTH+1 bits so a shifted-in remainder with its MSB set cannot overflow
    logic [WIDTH:0]   p_sh, p_sub;
    logic             p_ge;
    logic [WIDTH-1:0] p_step, q_step;
    logic             last;

    assign p_sh   = {p_q, q_q[WIDTH-1]};
    assign p_ge   = p_sh >= {1'b0, d_q};
    assign p_sub  = p_sh - {1'b0, d_q};
    assign p_step = p_ge ? p_sub[WIDTH-1:0] : p_sh[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], p_ge};
    assign last   = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        dz_d    = dz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (bus.op_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            p_d     = '0;
            q_d     = '0;
            d_d     = '0;
            dz_d    = 1'b0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_start) begin
                        cnt_d  = '0;
                        p_d    = '0;
                        q_d    = a_mag;
                        d_d    = b_mag;
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        dz_d   = bus.divisor == '0;
                        if (bus.divisor == '0) begin
                            state_d = DONE;
                            q_d     = '1;
                            p_d     = bus.dividend;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    p_d   = p_step;
                    q_d   = q_step;
                    if (last) begin
                        state_d = DONE;
                        if (qneg_q) q_d = -q_step;
                        if (rneg_q) p_d = -p_step;
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // Result registers trail the FSM by one edge and hold while in DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (bus.op_clear) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= state_q == EXEC;
            done_q <= state_q == DONE;
            if (state_q == DONE) begin
                dzo_q <= dz_q;
                quo_q <= q_q;
                rem_q <= p_q;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.op_done   = done_q;
    assign bus.div_zero  = dzo_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq, WIDTH=64.
// Signed vectors build only when SIGNED_DIV_EN is defined.
module tb_div_seq;

    localparam int W = 64;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_pass;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W), .CNT_W(7)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives op_start for one edge (edge 0), returns 1 ns after it
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn);
        bus.dividend = a;
        bus.divisor  = b;
`ifdef SIGNED_DIV_EN
        bus.div_signed = sgn;
`else
        if (sgn) $display("note: signed request ignored");
`endif
        bus.op_start = 1'b1;
        tick(1);
        bus.op_start = 1'b0;
    endtask

    task automatic clear();
        bus.op_clear = 1'b1;
        tick(1);
        bus.op_clear = 1'b0;
    endtask

    task automatic result(input string tag, input logic [W-1:0] q,
                          input logic [W-1:0] r);
        chk({tag, "_done"}, W'(bus.op_done), W'(1));
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, bus.remainder, r);
        chk({tag, "_dz"}, W'(bus.div_zero), W'(0));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset_n = 1'b0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
        bus.div_signed = 1'b0;
`endif
        tick(2);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.op_done), W'(0));
        chk("rst_q", bus.quotient, W'(0));
        reset_n = 1'b1;
        tick(1);

        // 100/7 with latency checks
        start(64'd100, 64'd7, 1'b0);
        chk("t1_busy_e0", W'(bus.busy), W'(0));
        tick(1);
        chk("t1_busy_e1", W'(bus.busy), W'(1));
        tick(63);
        chk("t1_busy_e64", W'(bus.busy), W'(1));
        chk("t1_done_e64", W'(bus.op_done), W'(0));
        tick(1);
        chk("t1_busy_e65", W'(bus.busy), W'(0));
        result("t1", 64'd14, 64'd2);

        // op_start in DONE is ignored, results hold
        start(64'd5, 64'd5, 1'b0);
        tick(3);
        result("t1hold", 64'd14, 64'd2);
        clear();
        chk("t1clr_done", W'(bus.op_done), W'(0));
        chk("t1clr_q", bus.quotient, W'(0));

        // divide by zero
        start(64'h1234, 64'd0, 1'b0);
        chk("t2_done_e0", W'(bus.op_done), W'(0));
        tick(1);
        chk("t2_done", W'(bus.op_done), W'(1));
        chk("t2_dz", W'(bus.div_zero), W'(1));
        chk("t2_q", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_r", bus.remainder, 64'h1234);
        clear();
        chk("t2clr_dz", W'(bus.div_zero), W'(0));

        // all-ones boundaries
        start('1, 64'd1, 1'b0);
        tick(65);
        result("t3a", '1, 64'd0);
        clear();
        start('1, '1, 1'b0);
        tick(65);
        result("t3b", 64'd1, 64'd0);
        clear();

        // abort at EXEC cycle 20, then a fresh 9/4
        start(64'd1000, 64'd3, 1'b0);
        tick(20);
        chk("t4_busy20", W'(bus.busy), W'(1));
        clear();
        chk("t4_busy", W'(bus.busy), W'(0));
        chk("t4_done", W'(bus.op_done), W'(0));
        chk("t4_r", bus.remainder, W'(0));
        tick(2);
        chk("t4_idle", W'(bus.busy), W'(0));

        // start and clear together: clear wins
        bus.dividend = 64'd8;
        bus.divisor  = 64'd2;
        bus.op_start = 1'b1;
        bus.op_clear = 1'b1;
        tick(1);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        tick(2);
        chk("t4_both_busy", W'(bus.busy), W'(0));
        chk("t4_both_done", W'(bus.op_done), W'(0));

        start(64'd9, 64'd4, 1'b0);
        tick(64);
        chk("t4b_done_e64", W'(bus.op_done), W'(0));
        tick(1);
        result("t4b", 64'd2, 64'd1);
        clear();

        // op_start during EXEC ignored
        start(64'd50, 64'd5, 1'b0);
        tick(29);
        start(64'd77, 64'd2, 1'b0);
        tick(35);
        result("t5", 64'd10, 64'd0);
        clear();

        // async reset mid-EXEC, then in DONE
        start(64'd123, 64'd10, 1'b0);
        tick(10);
        chk("t5_busy", W'(bus.busy), W'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", W'(bus.busy), W'(0));
        tick(1);
        reset_n = 1'b1;
        tick(70);
        chk("t5_rst_idle", W'(bus.op_done), W'(0));

        start(64'd123, 64'd10, 1'b0);
        tick(65);
        result("t5c", 64'd12, 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("t5c_rst_q", bus.quotient, W'(0));
        chk("t5c_rst_done", W'(bus.op_done), W'(0));
        tick(1);
        reset_n = 1'b1;
        tick(1);

`ifdef SIGNED_DIV_EN
        // truncation toward zero, remainder follows dividend
        start(-64'sd7, 64'sd2, 1'b1);
        tick(65);
        result("s1", -64'sd3, -64'sd1);
        clear();
        start(64'sd7, -64'sd2, 1'b1);
        tick(65);
        result("s2", -64'sd3, 64'sd1);
        clear();
        start(64'h8000_0000_0000_0000, '1, 1'b1);
        tick(65);
        result("s3", 64'h8000_0000_0000_0000, 64'd0);
        clear();
        start(-64'sd7, 64'd0, 1'b1);
        tick(1);
        chk("s4_dz", W'(bus.div_zero), W'(1));
        chk("s4_q", bus.quotient, '1);
        chk("s4_r", bus.remainder, -64'sd7);
        clear();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
